// File: rtl/dmem_responder.sv
// Word-addressed data RAM behind a valid/ready request channel with a fixed
// response latency of WAIT_STATES+1 cycles and error flagging for bad addresses.
module dmem_responder #(
   parameter int DEPTH_WORDS = 256,
   parameter int WAIT_STATES = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        req_valid,
   input  logic        req_write,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_error,
   output logic        busy
);

   localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

   typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;

   state_t      state;
   logic [3:0]  count;
   logic        lat_write;
   logic [31:0] lat_addr;
   logic [31:0] lat_wdata;
   logic [31:0] mem [DEPTH_WORDS];

   logic          accept;
   logic          commit;
   logic          eff_write;
   logic          eff_err;
   logic [31:0]   eff_addr;
   logic [31:0]   eff_wdata;
   logic [AW-1:0] eff_idx;

   assign req_ready = (state == ST_IDLE) && reset;
   assign busy      = (state != ST_IDLE);

   // With zero wait states the commit edge is the accept edge, so the live
   // request is used; otherwise the latched copy is.
   // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
   always_comb begin
      accept    = req_valid && req_ready;
      eff_write = (state == ST_IDLE) ? req_write : lat_write;
      eff_addr  = (state == ST_IDLE) ? req_addr  : lat_addr;
      eff_wdata = (state == ST_IDLE) ? req_wdata : lat_wdata;
      if (WAIT_STATES == 0) commit = accept;
      else                  commit = (state == ST_WAIT) && (count == 4'd0);
      eff_err = (eff_addr[1:0] != 2'b00) ||
                ({2'b00, eff_addr[31:2]} >= 32'(DEPTH_WORDS));
      eff_idx = eff_addr[AW+1:2];
   end

   // NOTE: the RAM array has no reset; its contents survive reset by design.
   always_ff @(posedge clock) begin
      if (reset && commit && eff_write && !eff_err)
         mem[eff_idx] <= eff_wdata;
   end

   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state      <= ST_IDLE;
         count      <= 4'd0;
         resp_valid <= 1'b0;
         resp_rdata <= 32'd0;
         resp_error <= 1'b0;
         lat_write  <= 1'b0;
         lat_addr   <= 32'd0;
         lat_wdata  <= 32'd0;
      end else begin
         resp_valid <= 1'b0;
         if (commit) begin
            resp_valid <= 1'b1;
            resp_error <= eff_err;
            resp_rdata <= (eff_write || eff_err) ? 32'd0 : mem[eff_idx];
         end
         case (state)
            ST_IDLE: begin
               if (accept) begin
                  lat_write <= req_write;
                  lat_addr  <= req_addr;
                  lat_wdata <= req_wdata;
                  if (WAIT_STATES == 0) begin
                     state <= ST_RESP;
                  end else begin
                     state <= ST_WAIT;
                     count <= 4'(WAIT_STATES - 1);
                  end
               end
            end
            ST_WAIT: begin
               if (count == 4'd0) state <= ST_RESP;
               else               count <= count - 4'd1;
            end
            ST_RESP: state <= ST_IDLE;
            default: state <= ST_IDLE;
         endcase
      end
   end

endmodule
